line_buffer_ctrl: RTL and testbench

LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

---
 rtl/line_buffer_ctrl.sv | 63 ++++++
 tb/tb_line_buffer_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: frame sequencing, pixel position tracking and 3x3 window
// qualification for a two-line-buffer image pipeline.
module line_buffer_ctrl #(
    parameter int NO_OF_COLS = 320,
    parameter int NO_OF_ROWS = 240,
    parameter int CW = $clog2(NO_OF_COLS),
    parameter int RW = $clog2(NO_OF_ROWS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          pix_valid,
    output logic          fsync,
    output logic          rsync,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          win_valid,
    output logic          border,
    output logic          frame_done,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;
    localparam logic [CW-1:0] COL_MAX = CW'(NO_OF_COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(NO_OF_ROWS - 1);
    state_t state, state_nxt;
    logic last_col, win_nxt, border_nxt;
    assign rsync      = pix_valid & fsync & ~frame_start;
    assign last_col   = col == COL_MAX;
    assign frame_done = state == DONE;
    assign busy       = state != IDLE;
    // A window centred one row/column behind the current pixel is complete
    // once two full rows and two columns of the current row have arrived.
    assign win_nxt    = rsync && row >= RW'(2) && col >= CW'(2);
    assign border_nxt = win_nxt && (row == RW'(2) || row == ROW_MAX || col == CW'(2) || col == COL_MAX);
    always_comb begin
        state_nxt = frame_start ? FILL :
                    state == DONE ? IDLE :
                    (rsync && last_col && state == FILL && row == RW'(1)) ? RUN :
                    (rsync && last_col && state == RUN && row == ROW_MAX) ? DONE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fsync     <= 1'b0;
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            border    <= 1'b0;
        end else begin
            state     <= state_nxt;
            fsync     <= state_nxt == FILL || state_nxt == RUN;
            win_valid <= win_nxt;
            border    <= border_nxt;
            if (frame_start) begin
                col <= '0;
                row <= '0;
            end else if (rsync) begin
                col <= last_col ? '0 : col + 1'b1;
                row <= (last_col && row != ROW_MAX) ? row + 1'b1 : row;
            end
        end
    end
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: directed scoreboard bench for line_buffer_ctrl on an
// 8x6 instance and a default 320x240 instance.
module tb_line_buffer_ctrl;
    localparam int C = 8;
    localparam int R = 6;
    typedef struct {int r; int c;} pix_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic frame_start = 1'b0, pix_valid = 1'b0;
    logic fsync, rsync, win_valid, border, frame_done, busy;
    logic [2:0] col, row;
    logic fs2 = 1'b0, pv2 = 1'b0;
    logic fsync2, rsync2, win2, border2, fd2, busy2;
    logic [8:0] col2;
    logic [7:0] row2;
    pix_t q[$];
    int n_assert = 0, n_fail = 0;
    int n_rs = 0, n_win = 0, n_bor = 0, n_fd = 0, n_win2 = 0, n_bor2 = 0;
    int b_rs, b_win, b_bor, b_fd;
    always #5 clk = ~clk;
    line_buffer_ctrl #(.NO_OF_COLS(C), .NO_OF_ROWS(R)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
        .fsync(fsync), .rsync(rsync), .col(col), .row(row), .win_valid(win_valid),
        .border(border), .frame_done(frame_done), .busy(busy)
    );
    line_buffer_ctrl dut_big (
        .clk(clk), .rst_n(rst_n), .frame_start(fs2), .pix_valid(pv2),
        .fsync(fsync2), .rsync(rsync2), .col(col2), .row(row2), .win_valid(win2),
        .border(border2), .frame_done(fd2), .busy(busy2)
    );
    always @(posedge clk) if (rsync) n_rs++;
    always @(negedge clk) begin
        if (win_valid) n_win++;
        if (border) n_bor++;
        if (frame_done) n_fd++;
        if (win2) n_win2++;
        if (border2) n_bor2++;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic cycle(input logic fs, input logic pv, input logic acc);
        pix_t p;
        logic ew, eb;
        @(negedge clk);
        frame_start = fs;
        pix_valid = pv;
        #1;
        chk("rsync", rsync, acc);
        ew = 1'b0;
        eb = 1'b0;
        if (acc) begin
            p = q.pop_front();
            chk("col", col, p.c);
            chk("row", row, p.r);
            ew = p.r >= 2 && p.c >= 2;
            eb = ew && (p.r == 2 || p.r == R - 1 || p.c == 2 || p.c == C - 1);
        end
        @(posedge clk);
        #1;
        chk("win_valid", win_valid, ew);
        chk("border", border, eb);
    endtask
    task automatic px(input int r, input int c, input bit gap);
        q.push_back('{r, c});
        cycle(1'b0, 1'b1, 1'b1);
        if (gap) cycle(1'b0, 1'b0, 1'b0);
    endtask
    task automatic frame(input bit gap);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) px(r, c, gap);
    endtask
    task automatic snap();
        b_rs = n_rs;
        b_win = n_win;
        b_bor = n_bor;
        b_fd = n_fd;
    endtask
    initial begin
        #3 rst_n = 1'b0;
        #1;
        chk("rst_col", col, 0);
        chk("rst_row", row, 0);
        chk("rst_fsync", fsync, 0);
        chk("rst_rsync", rsync, 0);
        chk("rst_win", win_valid, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // full frame, continuous pixels; pixel during DONE and IDLE ignored
        snap();
        cycle(1'b1, 1'b0, 1'b0);
        chk("fill_fsync", fsync, 1);
        chk("fill_busy", busy, 1);
        frame(1'b0);
        chk("done_fd", frame_done, 1);
        chk("done_busy", busy, 1);
        chk("done_fsync", fsync, 0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("idle_fd", frame_done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_col", col, 0);
        chk("idle_row", row, R - 1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("idle_col_hold", col, 0);
        chk("f1_rsync_cnt", n_rs - b_rs, R * C);
        chk("f1_win_cnt", n_win - b_win, (R - 2) * (C - 2));
        chk("f1_border_cnt", n_bor - b_bor, 2 * (C - 2) + 2 * (R - 2) - 4);
        chk("f1_fd_cnt", n_fd - b_fd, 1);
        // same frame with a gap after every pixel
        snap();
        cycle(1'b1, 1'b0, 1'b0);
        frame(1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("f2_busy", busy, 0);
        chk("f2_rsync_cnt", n_rs - b_rs, R * C);
        chk("f2_win_cnt", n_win - b_win, (R - 2) * (C - 2));
        chk("f2_fd_cnt", n_fd - b_fd, 1);
        // abort at (3,4), then frame_start colliding with a pixel
        snap();
        cycle(1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < C; c++)
                if (r < 3 || c < 4) px(r, c, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("abort_busy", busy, 1);
        for (int c = 0; c < 5; c++) px(0, c, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        frame(1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("f3_fd_cnt", n_fd - b_fd, 1);
        chk("f3_busy", busy, 0);
        // asynchronous reset mid-frame at row 4
        snap();
        cycle(1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < C; c++)
                if (r < 4 || c < 3) px(r, c, 1'b0);
        chk("pre_rst_win", win_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        pix_valid = 1'b1;
        #1;
        chk("mid_rst_col", col, 0);
        chk("mid_rst_row", row, 0);
        chk("mid_rst_fsync", fsync, 0);
        chk("mid_rst_rsync", rsync, 0);
        chk("mid_rst_win", win_valid, 0);
        chk("mid_rst_border", border, 0);
        chk("mid_rst_fd", frame_done, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("post_rst_col", col, 0);
        chk("post_rst_row", row, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_fd_cnt", n_fd - b_fd, 0);
        cycle(1'b1, 1'b0, 1'b0);
        frame(1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("f4_fd_cnt", n_fd - b_fd, 1);
        chk("sb_empty", q.size(), 0);
        // default 320x240 instance: four rows, checking column wrap and row step
        b_win = n_win2;
        b_bor = n_bor2;
        @(negedge clk);
        fs2 = 1'b1;
        @(negedge clk);
        fs2 = 1'b0;
        pv2 = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 320; c++) begin
                #1;
                chk("big_col", col2, c);
                chk("big_row", row2, r);
                @(negedge clk);
            end
        pv2 = 1'b0;
        @(negedge clk);
        #1;
        chk("big_col_wrapped", col2, 0);
        chk("big_row_held", row2, 4);
        chk("big_win_cnt", n_win2 - b_win, 2 * 318);
        chk("big_border_cnt", n_bor2 - b_bor, 318 + 2);
        chk("big_busy", busy2, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
